// File: rtl/ac_result_writer.sv
// Drains finished accumulator words into data memory in row-major element order.
// Define AC_WRITER_COLMAJOR_EN to store the same element stream column-major.
module ac_result_writer #(
  parameter int WORD_SIZE  = 24,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [DIM_WIDTH-1:0]   rows,
  input  logic [DIM_WIDTH-1:0]   cols,
  input  logic [WORD_SIZE-1:0]   ac_value,
  input  logic                   ac_valid,
  output logic                   ac_ready,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [WORD_SIZE-1:0]   mem_wdata,
  output logic                   mem_we,
  input  logic                   mem_ack,
  output logic                   busy,
  output logic                   done,
  output logic [2*DIM_WIDTH-1:0] count
);

  localparam int CW = 2 * DIM_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_AC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DIM_WIDTH-1:0]  rows_q, rows_d;
  logic [DIM_WIDTH-1:0]  cols_q, cols_d;
  logic [DIM_WIDTH-1:0]  r_q, r_d;
  logic [DIM_WIDTH-1:0]  c_q, c_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
`ifdef AC_WRITER_COLMAJOR_EN
  logic [ADDR_WIDTH-1:0] base_q, base_d;
`endif

  logic last_col;
  logic last_elem;

  assign last_col  = (c_q == cols_q - DIM_WIDTH'(1));
  assign last_elem = last_col && (r_q == rows_q - DIM_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    r_d     = r_q;
    c_d     = c_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef AC_WRITER_COLMAJOR_EN
    base_d  = base_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = '0;
          if (rows != '0 && cols != '0) begin
            rows_d  = rows;
            cols_d  = cols;
            r_d     = '0;
            c_d     = '0;
            addr_d  = base_addr;
`ifdef AC_WRITER_COLMAJOR_EN
            base_d  = base_addr;
`endif
            state_d = S_WAIT_AC;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WAIT_AC: begin
        if (ac_valid) begin
          wdata_d = ac_value;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          count_d = count_q + CW'(1);
          if (last_elem) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_AC;
            if (last_col) begin
              c_d = '0;
              r_d = r_q + DIM_WIDTH'(1);
`ifdef AC_WRITER_COLMAJOR_EN
              // new row starts one word below the previous row's first element
              addr_d = base_q + ADDR_WIDTH'(r_q + DIM_WIDTH'(1));
`else
              addr_d = addr_q + ADDR_WIDTH'(1);
`endif
            end else begin
              c_d = c_q + DIM_WIDTH'(1);
`ifdef AC_WRITER_COLMAJOR_EN
              addr_d = addr_q + ADDR_WIDTH'(rows_q);
`else
              addr_d = addr_q + ADDR_WIDTH'(1);
`endif
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef AC_WRITER_COLMAJOR_EN
      base_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      r_q     <= r_d;
      c_q     <= c_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef AC_WRITER_COLMAJOR_EN
      base_q  <= base_d;
`endif
    end
  end

  // Handshake outputs decode straight from state so reset clears them at once.
  assign ac_ready  = (state_q == S_WAIT_AC);
  assign mem_we    = (state_q == S_WRITE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;

endmodule

// File: doc/ac_result_writer.md
Name: ac_result_writer

Overview:
- Drains accumulator results into data memory for the matrix-multiply datapath.
- The control unit presents one finished AC word per output element in row-major (r,c) order.
- The block generates the destination address, performs the memory write handshake and counts the stored elements.
- It is the reader/consumer end of the accumulator write path: the accumulator is loaded from ALU/data bus, and this block empties it to memory.

Parameters:
WORD_SIZE, 24, width of accumulator/memory data word
ADDR_WIDTH, 16, width of memory address
DIM_WIDTH, 8, width of row/column dimension inputs

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a result-store job (sampled in IDLE only)
base_addr  input  ADDR_WIDTH  address of element (0,0)
rows  input  DIM_WIDTH  result matrix row count
cols  input  DIM_WIDTH  result matrix column count
ac_value  input  WORD_SIZE  accumulator output word
ac_valid  input  1  ac_value holds a finished element
ac_ready  output  1  block accepts ac_value this cycle
mem_addr  output  ADDR_WIDTH  write address
mem_wdata  output  WORD_SIZE  write data
mem_we  output  1  write request, held until mem_ack
mem_ack  input  1  memory accepted the write
busy  output  1  job in progress (any state except IDLE)
done  output  1  one-cycle pulse at job completion
count  output  2*DIM_WIDTH  elements written in the current/last job

Behaviour:
- Reset (async, any state): state=IDLE. Outputs: ac_ready=0, mem_we=0, done=0, busy=0, mem_addr=0, mem_wdata=0, count=0. Internal row/column counters are cleared. A reset mid-write abandons the write; nothing is retried.
- States: IDLE, WAIT_AC, WRITE, DONE.
- IDLE
  - start=1 with rows!=0 and cols!=0: latch base_addr/rows/cols, clear r/c/count, set the address pointer to base_addr, go to WAIT_AC.
  - start=1 with rows==0 or cols==0: go to DONE with count=0; no memory traffic.
  - count holds its last value until the next start.
- WAIT_AC: ac_ready=1. On ac_valid&&ac_ready, register ac_value into mem_wdata and go to WRITE. ac_valid without ready is ignored.
- WRITE
  - mem_we=1; mem_addr and mem_wdata are stable until mem_ack.
  - On mem_ack: count+=1, then:
    - if r==rows-1 and c==cols-1, go to DONE;
    - else advance c (wrap to 0 and r+=1 at cols-1) and go to WAIT_AC.
  - mem_ack is ignored outside WRITE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in WAIT_AC, WRITE and DONE.
- start is ignored while busy; the latched dims are unaffected.
- Latency:
  - ac_valid accepted at edge N; mem_we=1 from cycle N+1.
  - With zero-wait mem_ack, ac_ready is high again in cycle N+2.
  - Peak throughput is 1 element per 2 cycles.
- Address (row-major default): addr = base + r*cols + c, realised as pointer+1 per element. Arithmetic is modulo 2^ADDR_WIDTH; wrap past all-ones to 0 is silent.
- ac_ready and mem_we are never high in the same cycle.

Optional Feature:
- Macro AC_WRITER_COLMAJOR_EN.
- Defined: elements still arrive in row-major order but are stored column-major, addr = base + c*rows + r.
  - Pointer advances by rows within a row.
  - On row wrap the pointer reloads to base + r_new.
  - Same modulo rule.
- Undefined: row-major addressing as above. All other behaviour is identical.

Test Plan:
- rows=2, cols=3, base=0x0100, ac_valid always high, values 1..6, mem_ack tied high:
  - writes 1..6 to 0x0100..0x0105, one write every 2 cycles;
  - done pulses once after the 6th ack; count=6.
- Same job with mem_ack delayed 3 cycles per write: mem_addr/mem_wdata/mem_we held steady while waiting, ac_ready stays low throughout, same final memory image.
- start with rows=0, cols=5: DONE one cycle later, done pulse, mem_we never asserted, count=0.
- base=0xFFFE, rows=1, cols=4: addresses are 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Assert rst during WRITE of element 3 of a 2x2 job:
  - outputs go to reset values immediately, not at the next clock edge;
  - a new start with base=0x0200 restarts cleanly at element (0,0).
- With AC_WRITER_COLMAJOR_EN, rows=2, cols=3, base=0: values 1..6 land at addresses 0, 2, 4, 1, 3, 5.
